// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared constants and request bundle for the register-file write arbiter
package regfile_arb_pkg;

    // Requester indices on the shared write port
    localparam int PORT_ALU = 0;
    localparam int PORT_LSU = 1;

    // Default data width and register address width
    localparam int DEF_W = 8;
    localparam int DEF_D = 4;

    // One writeback request as seen by the select mux. Field widths follow
    // the package defaults, so the top must be built with W/D equal to them.
    typedef struct packed {
        logic [DEF_D-1:0] addr;
        logic [DEF_W-1:0] data;
        logic             flag_we;
        logic             zero;
        logic             done;
    } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// rtl/regfile_write_arbiter_rr_arbiter2.sv - two-requester round-robin arbiter with last-grant memory
module rr_arbiter2 (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // Index of the port granted most recently; 1 after reset so port 0 wins the first tie
    logic last_grant_q;
    logic last_grant_d;

    // Grant selection: a lone requester always wins, a tie goes to the port not granted last
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // The pointer only moves when something is actually granted
    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt != 2'b00) begin
            last_grant_d = gnt[1];
        end
    end

    // Last-grant register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin sharing of the register-file write port between ALU and LSU writeback
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int D = DEF_D
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic [1:0]        ReqValid,
    output logic [1:0]        ReqReady,
    input  logic [D-1:0]      ReqAddr0,
    input  logic [D-1:0]      ReqAddr1,
    input  logic [W-1:0]      ReqData0,
    input  logic [W-1:0]      ReqData1,
    input  logic [1:0]        ReqFlagWe,
    input  logic [1:0]        ReqZero,
    input  logic [1:0]        ReqDone,
    input  logic              CurZero,
    input  logic              CurDone,
    output logic              WriteEn,
    output logic [D-1:0]      Waddr,
    output logic [W-1:0]      DataIn,
    output logic              Zero_in,
    output logic              Done_in,
    output logic [(1<<D)-1:0] PendMask
);

    localparam int NREG = 1 << D;

    wr_req_t    req [2];
    wr_req_t    sel;
    logic [1:0] gnt;
    logic       arb_en;

    logic         we_q,      we_d;
    logic [D-1:0] waddr_q,   waddr_d;
    logic [W-1:0] data_q,    data_d;
    logic         zero_q,    zero_d;
    logic         done_q,    done_d;
    // Set while the write now in the output stage carries its own flags,
    // meaning the register file's CurZero/CurDone do not reflect it yet
    logic         flag_we_q, flag_we_d;

    logic         keep_zero;
    logic         keep_done;

    // No grants while in reset or frozen
    assign arb_en = Reset & ~Stall;

    rr_arbiter2 u_arb (
        .Clk   (Clk),
        .Reset (Reset),
        .req   (ReqValid),
        .en    (arb_en),
        .gnt   (gnt)
    );

    assign ReqReady = gnt;

    // Gather each requester's fields into one bundle for the select mux
    always_comb begin
        req[PORT_ALU].addr    = ReqAddr0;
        req[PORT_ALU].data    = ReqData0;
        req[PORT_ALU].flag_we = ReqFlagWe[PORT_ALU];
        req[PORT_ALU].zero    = ReqZero[PORT_ALU];
        req[PORT_ALU].done    = ReqDone[PORT_ALU];
        req[PORT_LSU].addr    = ReqAddr1;
        req[PORT_LSU].data    = ReqData1;
        req[PORT_LSU].flag_we = ReqFlagWe[PORT_LSU];
        req[PORT_LSU].zero    = ReqZero[PORT_LSU];
        req[PORT_LSU].done    = ReqDone[PORT_LSU];
    end

    // Output-stage next state: load the granted request, otherwise hold fields and drop WriteEn
    always_comb begin
        sel       = gnt[PORT_LSU] ? req[PORT_LSU] : req[PORT_ALU];
        // Flags to preserve: the register file lags one cycle behind a flag-writing commit
        keep_zero = flag_we_q ? zero_q : CurZero;
        keep_done = flag_we_q ? done_q : CurDone;

        we_d      = |gnt;
        waddr_d   = waddr_q;
        data_d    = data_q;
        zero_d    = zero_q;
        done_d    = done_q;
        flag_we_d = 1'b0;

        if (|gnt) begin
            waddr_d   = sel.addr;
            data_d    = sel.data;
            flag_we_d = sel.flag_we;
            zero_d    = sel.flag_we ? sel.zero : keep_zero;
            done_d    = sel.flag_we ? sel.done : keep_done;
        end
    end

    // Output-stage registers
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            we_q      <= 1'b0;
            waddr_q   <= '0;
            data_q    <= '0;
            zero_q    <= 1'b0;
            done_q    <= 1'b1;
            flag_we_q <= 1'b0;
        end else begin
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            data_q    <= data_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
            flag_we_q <= flag_we_d;
        end
    end

    assign WriteEn = we_q;
    assign Waddr   = waddr_q;
    assign DataIn  = data_q;
    assign Zero_in = zero_q;
    assign Done_in = done_q;

    // Pending-write mask: the write in flight plus any live request, forced clear in reset
    always_comb begin
        PendMask = '0;
        if (Reset) begin
            for (int i = 0; i < NREG; i++) begin
                PendMask[i] = (we_q && (waddr_q == D'(i)))
                            | (ReqValid[PORT_ALU] && (ReqAddr0 == D'(i)))
                            | (ReqValid[PORT_LSU] && (ReqAddr1 == D'(i)));
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic [1:0]  ReqValid;
    logic [1:0]  ReqReady;
    logic [3:0]  ReqAddr0, ReqAddr1;
    logic [7:0]  ReqData0, ReqData1;
    logic [1:0]  ReqFlagWe, ReqZero, ReqDone;
    logic        CurZero, CurDone;
    logic        WriteEn;
    logic [3:0]  Waddr;
    logic [7:0]  DataIn;
    logic        Zero_in, Done_in;
    logic [15:0] PendMask;

    regfile_write_arbiter #(.W(8), .D(4)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqAddr0(ReqAddr0), .ReqAddr1(ReqAddr1), .ReqData0(ReqData0), .ReqData1(ReqData1),
        .ReqFlagWe(ReqFlagWe), .ReqZero(ReqZero), .ReqDone(ReqDone),
        .CurZero(CurZero), .CurDone(CurDone), .WriteEn(WriteEn), .Waddr(Waddr),
        .DataIn(DataIn), .Zero_in(Zero_in), .Done_in(Done_in), .PendMask(PendMask)
    );

    always #5 Clk = ~Clk;

    // Register file environment: stores data and flags on every WriteEn
    logic [7:0] rf [16];
    logic       env_zero, env_done;
    assign CurZero = env_zero;
    assign CurDone = env_done;

    always @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
            env_zero <= 1'b0;
            env_done <= 1'b1;
        end else if (WriteEn) begin
            rf[Waddr] <= DataIn;
            env_zero  <= Zero_in;
            env_done  <= Done_in;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural flags, grant history and expected commit stream
    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        logic       z;
        logic       dn;
    } exp_t;

    exp_t       sb [$];
    int         m_last;
    logic       m_z, m_d;
    logic [3:0] o_a;
    logic [7:0] o_d;
    logic       o_z, o_dn;
    logic [7:0] mrf [16];
    logic [1:0] m_gnt = 2'b00;
    bit         rst_seen = 1'b0;

    // Monitor: compares outputs each cycle, then records this cycle's grant as a future commit
    always @(negedge Clk) begin
        logic [1:0]  eg;
        logic        ewe;
        logic [15:0] ep;
        exp_t        e;
        int          p;
        if (!Reset) begin
            chk("rst_ready", 32'(ReqReady), 32'd0);
            chk("rst_pend", 32'(PendMask), 32'd0);
            if (rst_seen) begin
                chk("rst_we", 32'(WriteEn), 32'd0);
                chk("rst_waddr", 32'(Waddr), 32'd0);
                chk("rst_data", 32'(DataIn), 32'd0);
                chk("rst_zero", 32'(Zero_in), 32'd0);
                chk("rst_done", 32'(Done_in), 32'd1);
            end
            rst_seen = 1'b1;
            m_last = 1;
            sb.delete();
            m_z = 1'b0; m_d = 1'b1;
            o_a = 4'd0; o_d = 8'd0; o_z = 1'b0; o_dn = 1'b1;
            for (int i = 0; i < 16; i++) mrf[i] = 8'h00;
            m_gnt = 2'b00;
        end else begin
            ewe = 1'b0;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                ewe = 1'b1;
                o_a = e.a; o_d = e.d; o_z = e.z; o_dn = e.dn;
            end
            chk("write_en", 32'(WriteEn), 32'(ewe));
            chk("waddr", 32'(Waddr), 32'(o_a));
            chk("data_in", 32'(DataIn), 32'(o_d));
            chk("zero_in", 32'(Zero_in), 32'(o_z));
            chk("done_in", 32'(Done_in), 32'(o_dn));

            eg = 2'b00;
            if (!Stall) begin
                if (ReqValid == 2'b11) eg = (m_last == 1) ? 2'b01 : 2'b10;
                else                   eg = ReqValid;
            end
            chk("req_ready", 32'(ReqReady), 32'(eg));

            ep = 16'h0000;
            if (ewe) ep[o_a] = 1'b1;
            if (ReqValid[0]) ep[ReqAddr0] = 1'b1;
            if (ReqValid[1]) ep[ReqAddr1] = 1'b1;
            chk("pend_mask", 32'(PendMask), 32'(ep));

            if (eg != 2'b00) begin
                p = eg[1] ? 1 : 0;
                if (ReqFlagWe[p]) begin
                    m_z = ReqZero[p];
                    m_d = ReqDone[p];
                end
                e.a  = (p == 1) ? ReqAddr1 : ReqAddr0;
                e.d  = (p == 1) ? ReqData1 : ReqData0;
                e.z  = m_z;
                e.dn = m_d;
                sb.push_back(e);
                mrf[e.a] = e.d;
                m_last = p;
            end
            m_gnt = eg;
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic set0(input logic [3:0] a, input logic [7:0] d, input logic fwe, input logic z, input logic dn);
        ReqAddr0 = a; ReqData0 = d; ReqFlagWe[0] = fwe; ReqZero[0] = z; ReqDone[0] = dn;
    endtask

    task automatic set1(input logic [3:0] a, input logic [7:0] d, input logic fwe, input logic z, input logic dn);
        ReqAddr1 = a; ReqData1 = d; ReqFlagWe[1] = fwe; ReqZero[1] = z; ReqDone[1] = dn;
    endtask

    initial begin
        Reset = 1'b0; Stall = 1'b0; ReqValid = 2'b00;
        ReqFlagWe = 2'b00; ReqZero = 2'b00; ReqDone = 2'b00;
        set0(4'd1, 8'h10, 1'b1, 1'b0, 1'b1);
        set1(4'd2, 8'h20, 1'b1, 1'b0, 1'b1);

        // Reset with both requesters valid, then release: port 0 takes the first tie
        ReqValid = 2'b11;
        repeat (2) cyc();
        Reset = 1'b1;
        cyc();
        ReqValid = 2'b10;
        cyc();
        ReqValid = 2'b00;
        cyc();

        // Sustained contention on addresses 1 and 2
        ReqValid = 2'b11;
        repeat (4) cyc();
        ReqValid = 2'b00;
        repeat (2) cyc();

        // Port 0 alone with its own flags
        set0(4'd3, 8'hA5, 1'b1, 1'b0, 1'b0);
        ReqValid = 2'b01;
        cyc();
        ReqValid = 2'b00;
        repeat (2) cyc();

        // Flag-preserving write right behind a flag-writing one
        set0(4'd4, 8'h44, 1'b1, 1'b1, 1'b0);
        ReqValid = 2'b01;
        cyc();
        set1(4'd6, 8'h66, 1'b0, 1'b0, 1'b1);
        ReqValid = 2'b10;
        cyc();
        ReqValid = 2'b00;
        repeat (2) cyc();

        // Stall for three cycles with port 1 waiting
        set1(4'd7, 8'h77, 1'b1, 1'b0, 1'b1);
        ReqValid = 2'b10;
        Stall = 1'b1;
        repeat (3) cyc();
        Stall = 1'b0;
        cyc();
        ReqValid = 2'b00;
        repeat (2) cyc();

        // Same-address conflict with last grant on port 0
        set0(4'd0, 8'h01, 1'b0, 1'b0, 1'b0);
        ReqValid = 2'b01;
        cyc();
        set0(4'd5, 8'h11, 1'b0, 1'b0, 1'b0);
        set1(4'd5, 8'h22, 1'b0, 1'b0, 1'b0);
        ReqValid = 2'b11;
        cyc();
        ReqValid = 2'b01;
        cyc();
        ReqValid = 2'b00;
        repeat (3) cyc();
        chk("reg5_last_write", 32'(rf[5]), 32'h11);

        // Randomized traffic; an unaccepted request keeps its fields
        for (int c = 0; c < 400; c++) begin
            if (!ReqValid[0] || m_gnt[0]) begin
                ReqValid[0] = ($urandom_range(3) != 0);
                set0(4'($urandom_range(15)), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end
            if (!ReqValid[1] || m_gnt[1]) begin
                ReqValid[1] = ($urandom_range(3) != 0);
                set1(4'($urandom_range(15)), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end
            Stall = ($urandom_range(7) == 0);
            cyc();
        end
        ReqValid = 2'b00;
        Stall = 1'b0;
        repeat (3) cyc();

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("regfile_%0d", i), 32'(rf[i]), 32'(mrf[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
